// File: rtl/game_pkg.sv
// Shared game types and default timing constants.
package game_pkg;

  typedef enum logic [2:0] {
    SL_WAIT_START = 3'd0,
    SL_ALIVE      = 3'd1,
    SL_DYING      = 3'd2,
    SL_RESPAWN    = 3'd3,
    SL_INVULN     = 3'd4,
    SL_GAME_OVER  = 3'd5
  } sl_state_t;

  localparam int unsigned LIVES_W = 3;

  localparam int unsigned LIVES_INIT_DEF    = 3;
  localparam int unsigned RESPAWN_DELAY_DEF = 1_000_000;
  localparam int unsigned INVULN_CYCLES_DEF = 2_000_000;
  localparam int unsigned BLINK_PERIOD_DEF  = 250_000;
  localparam int unsigned CNT_W_DEF         = 24;

endpackage

// File: rtl/cycle_timer.sv
// Cycle counter with clear and enable; expire is high on the terminal count and the counter
// wraps to zero on that edge.
module cycle_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  assign expire = enable && (count_q == terminal);

  always_ff @(posedge pclk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      if (expire) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ship_life_ctl.sv
// Player ship life-cycle sequencer: start, alive, hit, respawn delay, invulnerability, game over.
// Optional invulnerability blinking is enabled by defining SHIP_BLINK_EN.
module ship_life_ctl #(
  parameter int unsigned LIVES_INIT    = game_pkg::LIVES_INIT_DEF,
  parameter int unsigned LIVES_W       = game_pkg::LIVES_W,
  parameter int unsigned RESPAWN_DELAY = game_pkg::RESPAWN_DELAY_DEF,
  parameter int unsigned INVULN_CYCLES = game_pkg::INVULN_CYCLES_DEF,
  parameter int unsigned BLINK_PERIOD  = game_pkg::BLINK_PERIOD_DEF,
  parameter int unsigned CNT_W         = game_pkg::CNT_W_DEF
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  output logic               dead_s,
  output logic [LIVES_W-1:0] lives,
  output logic               ship_active,
  output logic               ship_visible,
  output logic               game_over
);

  import game_pkg::*;

  localparam logic [LIVES_W-1:0] LIVES_RST   = LIVES_W'(LIVES_INIT);
  localparam logic [CNT_W-1:0]   RESP_TERM   = CNT_W'(RESPAWN_DELAY - 1);
  localparam logic [CNT_W-1:0]   INVULN_TERM = CNT_W'(INVULN_CYCLES - 1);

  sl_state_t        state;
  logic             tmr_en;
  logic             tmr_expire;
  logic [CNT_W-1:0] tmr_term;
  logic             blink_toggle;

  // One timer serves both RESPAWN and INVULN; it is held clear in every other state so each
  // phase starts from zero.
  assign tmr_en   = (state == SL_RESPAWN) || (state == SL_INVULN);
  assign tmr_term = (state == SL_RESPAWN) ? RESP_TERM : INVULN_TERM;

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .pclk     (pclk),
    .rst      (rst),
    .clear    (!tmr_en),
    .enable   (tmr_en),
    .terminal (tmr_term),
    .expire   (tmr_expire)
  );

`ifdef SHIP_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_TERM = CNT_W'(BLINK_PERIOD - 1);

  logic blink_en;

  assign blink_en = (state == SL_INVULN);

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_blink_timer (
    .pclk     (pclk),
    .rst      (rst),
    .clear    (!blink_en),
    .enable   (blink_en),
    .terminal (BLINK_TERM),
    .expire   (blink_toggle)
  );
`else
  assign blink_toggle = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= SL_WAIT_START;
      lives        <= LIVES_RST;
      dead_s       <= 1'b0;
      ship_active  <= 1'b0;
      ship_visible <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      dead_s <= 1'b0;
      case (state)
        SL_WAIT_START, SL_GAME_OVER: begin
          if (start) begin
            state        <= SL_ALIVE;
            lives        <= LIVES_RST;
            ship_active  <= 1'b1;
            ship_visible <= 1'b1;
            game_over    <= 1'b0;
          end
        end
        SL_ALIVE: begin
          if (hit) begin
            state        <= SL_DYING;
            dead_s       <= 1'b1;
            lives        <= (lives == '0) ? lives : lives - LIVES_W'(1);
            ship_active  <= 1'b0;
            ship_visible <= 1'b0;
          end
        end
        SL_DYING: begin
          if (lives == '0) begin
            state     <= SL_GAME_OVER;
            game_over <= 1'b1;
          end else begin
            state <= SL_RESPAWN;
          end
        end
        SL_RESPAWN: begin
          if (tmr_expire) begin
            state        <= SL_INVULN;
            ship_visible <= 1'b1;
          end
        end
        SL_INVULN: begin
          // Leaving INVULN always shows the ship, whatever the blink phase.
          if (tmr_expire) begin
            state        <= SL_ALIVE;
            ship_active  <= 1'b1;
            ship_visible <= 1'b1;
          end else if (blink_toggle) begin
            ship_visible <= ~ship_visible;
          end
        end
        default: begin
          state        <= SL_WAIT_START;
          lives        <= LIVES_RST;
          ship_active  <= 1'b0;
          ship_visible <= 1'b0;
          game_over    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ship_life_ctl.sv
// Directed bench for ship_life_ctl; expected outputs are queued per step and checked after the edge.
module tb_ship_life_ctl;

  logic       pclk;
  logic       rst;
  logic       start;
  logic       hit;
  logic       dead_s;
  logic [2:0] lives;
  logic       ship_active;
  logic       ship_visible;
  logic       game_over;

  typedef struct packed {
    logic       dead_s;
    logic [2:0] lives;
    logic       active;
    logic       visible;
    logic       game_over;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  ship_life_ctl #(
    .LIVES_INIT    (3),
    .LIVES_W       (3),
    .RESPAWN_DELAY (8),
    .INVULN_CYCLES (16),
    .BLINK_PERIOD  (4),
    .CNT_W         (24)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .start        (start),
    .hit          (hit),
    .dead_s       (dead_s),
    .lives        (lives),
    .ship_active  (ship_active),
    .ship_visible (ship_visible),
    .game_over    (game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic obs_t mk(logic d, logic [2:0] l, logic a, logic v, logic g);
    obs_t o;
    o = {d, l, a, v, g};
    return o;
  endfunction

  // Visibility expected in INVULN cycle i (0-based).
  function automatic logic inv_vis(int i);
`ifdef SHIP_BLINK_EN
    return ((i / 4) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic compare();
    obs_t  e;
    obs_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {dead_s, lives, ship_active, ship_visible, game_over};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed={dead,lives,act,vis,go}=%b expected=%b", t, o, e);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic h, input obs_t e,
                      input string tag);
    rst   = r;
    start = s;
    hit   = h;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge pclk);
    @(negedge pclk);
    compare();
  endtask

  // 8 hidden cycles, 16 invulnerable cycles, then ALIVE with lv lives.
  task automatic respawn_seq(input logic s, input logic h, input logic [2:0] lv);
    for (int i = 0; i < 8; i++) step(1'b0, s, h, mk(1'b0, lv, 1'b0, 1'b0, 1'b0), "respawn");
    for (int i = 0; i < 16; i++) step(1'b0, s, h, mk(1'b0, lv, 1'b0, inv_vis(i), 1'b0), "invuln");
    step(1'b0, 1'b0, 1'b0, mk(1'b0, lv, 1'b1, 1'b1, 1'b0), "alive_again");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    obs_t rst_o;
    obs_t a3;
    rst_o = mk(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    a3    = mk(1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    start = 1'b0;
    hit = 1'b0;
    @(negedge pclk);

    // Reset and start
    step(1'b1, 1'b0, 1'b0, rst_o, "reset");
    step(1'b0, 1'b0, 1'b1, rst_o, "wait_hit_ignored");
    step(1'b0, 1'b1, 1'b0, a3, "start");
    step(1'b0, 1'b1, 1'b0, a3, "start_held_in_alive");
    step(1'b0, 1'b0, 1'b0, a3, "alive");

    // Single hit then full respawn
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "hit");
    respawn_seq(1'b0, 1'b0, 3'd2);

    // Hit held for 40 cycles
    step(1'b1, 1'b0, 1'b0, rst_o, "rst_before_held");
    step(1'b0, 1'b1, 1'b0, a3, "start_held_test");
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "held_hit1");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, mk(1'b0, 3'd2, 1'b0, 1'b0, 1'b0), "held_resp");
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 1'b1, mk(1'b0, 3'd2, 1'b0, inv_vis(i), 1'b0), "held_inv");
    step(1'b0, 1'b0, 1'b1, mk(1'b0, 3'd2, 1'b1, 1'b1, 1'b0), "held_alive");
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd1, 1'b0, 1'b0, 1'b0), "held_hit2");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, mk(1'b0, 3'd1, 1'b0, 1'b0, 1'b0), "held_resp2");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, mk(1'b0, 3'd1, 1'b0, inv_vis(i), 1'b0), "held_inv2");
    for (int i = 5; i < 16; i++)
      step(1'b0, 1'b0, 1'b0, mk(1'b0, 3'd1, 1'b0, inv_vis(i), 1'b0), "rel_inv2");
    step(1'b0, 1'b0, 1'b0, mk(1'b0, 3'd1, 1'b1, 1'b1, 1'b0), "held_done");

    // Three hits to game over, start ignored while respawning
    step(1'b1, 1'b0, 1'b0, rst_o, "rst_before_go");
    step(1'b0, 1'b1, 1'b0, a3, "start_go_test");
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "go_hit1");
    respawn_seq(1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd1, 1'b0, 1'b0, 1'b0), "go_hit2");
    respawn_seq(1'b0, 1'b1, 3'd1);
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd0, 1'b0, 1'b0, 1'b0), "go_hit3");
    step(1'b0, 1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1), "game_over");
    step(1'b0, 1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1), "go_hit_ignored");
    step(1'b0, 1'b0, 1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1), "go_idle");
    step(1'b0, 1'b1, 1'b1, a3, "go_start_wins");

    // Reset in DYING and mid-RESPAWN
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "hit_before_rst");
    step(1'b1, 1'b0, 1'b0, rst_o, "rst_in_dying");
    step(1'b0, 1'b0, 1'b0, rst_o, "after_rst_dying");
    step(1'b0, 1'b1, 1'b0, a3, "start_again");
    step(1'b0, 1'b0, 1'b1, mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "hit_again");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, mk(1'b0, 3'd2, 1'b0, 1'b0, 1'b0), "resp_part");
    step(1'b1, 1'b0, 1'b0, rst_o, "rst_mid_respawn");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, rst_o, "after_rst_resp");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard observed=%0d expected=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
